// File: rtl/butterfly_xbar_in_pkg.sv
// butterfly_xbar_pkg: shared lane counts and stride classification for the FFT read crossbar
package butterfly_xbar_pkg;
  localparam int NUM_BFLY = 4;
  localparam int LANES = 4;
  typedef enum logic [1:0] {SM_LT2, SM_EQ2, SM_GT2} stride_mode_e;
  function automatic stride_mode_e stride_mode(input logic [31:0] stride);
    return stride > 32'd2 ? SM_GT2 : stride == 32'd2 ? SM_EQ2 : SM_LT2;
  endfunction
  function automatic logic is_pow2(input logic [31:0] stride);
    return stride != 32'd0 && (stride & (stride - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/butterfly_xbar_in_perm.sv
// butterfly_xbar_in_perm: combinational de-interleave of two read words into butterfly TOP/BOTTOM operands
module butterfly_xbar_in_perm
  import butterfly_xbar_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LANES*DATA_W-1:0]    r1,
  input  logic [LANES*DATA_W-1:0]    r2,
  input  stride_mode_e               mode,
  output logic [NUM_BFLY*DATA_W-1:0] top,
  output logic [NUM_BFLY*DATA_W-1:0] bot
);
  logic [DATA_W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
  assign {a3, a2, a1, a0} = r1;
  assign {b3, b2, b1, b0} = r2;
  // operand n sits in bits [(n-1)*DATA_W +: DATA_W]
  always_comb begin
    top = mode == SM_GT2 ? r1 : mode == SM_EQ2 ? {b1, b0, a1, a0} : {b2, b0, a2, a0};
    bot = mode == SM_GT2 ? r2 : mode == SM_EQ2 ? {b3, b2, a3, a2} : {b3, b1, a3, a1};
  end
endmodule

// File: rtl/butterfly_xbar_in.sv
// butterfly_xbar_in: read-side crossbar feeding four butterflies through a registered valid/ready stage.
// Define BUTTERFLY_XBAR_IN_SKID_EN to add a skid entry so o_IN_READY has no path from i_OUT_READY.
module butterfly_xbar_in
  import butterfly_xbar_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STRIDE_W = 10,
  parameter int CNT_W    = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic                    i_CLEAR,
  input  logic [STRIDE_W-1:0]     i_STRIDE,
  input  logic                    i_IN_VALID,
  output logic                    o_IN_READY,
  input  logic [LANES*DATA_W-1:0] i_READ_INPUT1,
  input  logic [LANES*DATA_W-1:0] i_READ_INPUT2,
  output logic                    o_OUT_VALID,
  input  logic                    i_OUT_READY,
  output logic [DATA_W-1:0]       o_BUTTERFLY_1_TOP,
  output logic [DATA_W-1:0]       o_BUTTERFLY_2_TOP,
  output logic [DATA_W-1:0]       o_BUTTERFLY_3_TOP,
  output logic [DATA_W-1:0]       o_BUTTERFLY_4_TOP,
  output logic [DATA_W-1:0]       o_BUTTERFLY_1_BOTTOM,
  output logic [DATA_W-1:0]       o_BUTTERFLY_2_BOTTOM,
  output logic [DATA_W-1:0]       o_BUTTERFLY_3_BOTTOM,
  output logic [DATA_W-1:0]       o_BUTTERFLY_4_BOTTOM,
  output logic                    o_STRIDE_ERR,
  output logic [CNT_W-1:0]        o_BEAT_COUNT
);
  localparam int VW = NUM_BFLY * DATA_W;
  stride_mode_e mode;
  logic [VW-1:0] p_top, p_bot, q_top, q_bot;
  logic in_hs, out_hs, out_free;
  assign mode = stride_mode(32'(i_STRIDE));
  butterfly_xbar_in_perm #(.DATA_W(DATA_W)) u_perm (
    .r1  (i_READ_INPUT1),
    .r2  (i_READ_INPUT2),
    .mode(mode),
    .top (p_top),
    .bot (p_bot)
  );
  assign out_free = !o_OUT_VALID | i_OUT_READY;
  assign out_hs   = o_OUT_VALID & i_OUT_READY;
  assign in_hs    = i_IN_VALID & o_IN_READY;
`ifdef BUTTERFLY_XBAR_IN_SKID_EN
  logic skid_valid;
  logic [VW-1:0] s_top, s_bot;
  assign o_IN_READY = !skid_valid & !i_RESET;
  // the skid only fills while the output is stalled, so it always drains before new input
  always_ff @(posedge i_CLK or posedge i_RESET)
    if (i_RESET) begin
      o_OUT_VALID <= 1'b0;
      skid_valid  <= 1'b0;
      q_top       <= '0;
      q_bot       <= '0;
      s_top       <= '0;
      s_bot       <= '0;
    end else if (skid_valid) begin
      if (out_free) begin
        q_top      <= s_top;
        q_bot      <= s_bot;
        skid_valid <= 1'b0;
      end
    end else if (in_hs) begin
      if (out_free) begin
        q_top       <= p_top;
        q_bot       <= p_bot;
        o_OUT_VALID <= 1'b1;
      end else begin
        s_top      <= p_top;
        s_bot      <= p_bot;
        skid_valid <= 1'b1;
      end
    end else if (out_hs) o_OUT_VALID <= 1'b0;
`else
  assign o_IN_READY = out_free & !i_RESET;
  always_ff @(posedge i_CLK or posedge i_RESET)
    if (i_RESET) begin
      o_OUT_VALID <= 1'b0;
      q_top       <= '0;
      q_bot       <= '0;
    end else if (in_hs) begin
      q_top       <= p_top;
      q_bot       <= p_bot;
      o_OUT_VALID <= 1'b1;
    end else if (out_hs) o_OUT_VALID <= 1'b0;
`endif
  // a new illegal stride wins over a simultaneous clear
  always_ff @(posedge i_CLK or posedge i_RESET)
    if (i_RESET) begin
      o_BEAT_COUNT <= '0;
      o_STRIDE_ERR <= 1'b0;
    end else begin
      o_BEAT_COUNT <= i_CLEAR ? '0 : o_BEAT_COUNT + CNT_W'(out_hs);
      o_STRIDE_ERR <= (in_hs & !is_pow2(32'(i_STRIDE))) | (o_STRIDE_ERR & !i_CLEAR);
    end
  assign o_BUTTERFLY_1_TOP    = q_top[0*DATA_W +: DATA_W];
  assign o_BUTTERFLY_2_TOP    = q_top[1*DATA_W +: DATA_W];
  assign o_BUTTERFLY_3_TOP    = q_top[2*DATA_W +: DATA_W];
  assign o_BUTTERFLY_4_TOP    = q_top[3*DATA_W +: DATA_W];
  assign o_BUTTERFLY_1_BOTTOM = q_bot[0*DATA_W +: DATA_W];
  assign o_BUTTERFLY_2_BOTTOM = q_bot[1*DATA_W +: DATA_W];
  assign o_BUTTERFLY_3_BOTTOM = q_bot[2*DATA_W +: DATA_W];
  assign o_BUTTERFLY_4_BOTTOM = q_bot[3*DATA_W +: DATA_W];
endmodule

// File: tb/tb_butterfly_xbar_in.sv
// tb_butterfly_xbar_in: table-driven and randomized checks of the read crossbar against a lane-mapping model
module tb_butterfly_xbar_in;
  localparam int W = 32;
  localparam int CW = 4;
  logic clk = 0, rst = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [9:0] stride = 0;
  logic [127:0] r1 = 0, r2 = 0;
  logic in_ready, out_valid, serr;
  logic [CW-1:0] cnt;
  logic [W-1:0] t1, t2, t3, t4, b1, b2, b3, b4;
  logic [255:0] act;
  assign act = {b4, b3, b2, b1, t4, t3, t2, t1};
  butterfly_xbar_in #(.DATA_W(W), .STRIDE_W(10), .CNT_W(CW)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_CLEAR(clr), .i_STRIDE(stride),
    .i_IN_VALID(in_valid), .o_IN_READY(in_ready),
    .i_READ_INPUT1(r1), .i_READ_INPUT2(r2),
    .o_OUT_VALID(out_valid), .i_OUT_READY(out_ready),
    .o_BUTTERFLY_1_TOP(t1), .o_BUTTERFLY_2_TOP(t2), .o_BUTTERFLY_3_TOP(t3), .o_BUTTERFLY_4_TOP(t4),
    .o_BUTTERFLY_1_BOTTOM(b1), .o_BUTTERFLY_2_BOTTOM(b2), .o_BUTTERFLY_3_BOTTOM(b3), .o_BUTTERFLY_4_BOTTOM(b4),
    .o_STRIDE_ERR(serr), .o_BEAT_COUNT(cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0]   s;
    logic [255:0] e;
  } vec_t;
  logic [255:0] q[$];
  logic [255:0] prev;
  bit prev_stall, merr;
  int mcnt, checks, errors;
  // operand n of TOP at slot n-1, operand n of BOTTOM at slot n+3
  function automatic logic [255:0] model(input logic [9:0] s, input logic [127:0] a, input logic [127:0] b);
    logic [255:0] e;
    logic [31:0] lane;
    int bf;
    bit top;
    e = '0;
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 4; j++) begin
        lane = w == 1 ? b[j*32 +: 32] : a[j*32 +: 32];
        if (s > 2) begin
          bf = j;
          top = w == 0;
        end else if (s == 2) begin
          bf = w * 2 + j % 2;
          top = j < 2;
        end else begin
          bf = w * 2 + j / 2;
          top = j % 2 == 0;
        end
        e[(top ? bf : bf + 4)*32 +: 32] = lane;
      end
    return e;
  endfunction
  function automatic logic [255:0] pk(input logic [31:0] x1, x2, x3, x4, y1, y2, y3, y4);
    return {y4, y3, y2, y1, x4, x3, x2, x1};
  endfunction
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic cyc(input bit v, input bit rdy, input bit c, input logic [9:0] s,
                     input logic [127:0] a, input logic [127:0] b, input logic [255:0] e, output bit acc);
    bit er, ho;
    @(negedge clk);
    chk("valid", 256'(out_valid), 256'(q.size() != 0));
    if (q.size() != 0) chk("data", act, q[0]);
    if (prev_stall) chk("stable", act, prev);
    chk("count", 256'(cnt), 256'(mcnt));
    chk("stride_err", 256'(serr), 256'(merr));
    in_valid = v; out_ready = rdy; clr = c; stride = s; r1 = a; r2 = b;
    #1;
`ifdef BUTTERFLY_XBAR_IN_SKID_EN
    er = q.size() < 2;
`else
    er = q.size() == 0 || rdy;
`endif
    chk("in_ready", 256'(in_ready), 256'(er));
    acc = v && er;
    ho = q.size() != 0 && rdy;
    prev_stall = q.size() != 0 && !rdy;
    prev = act;
    if (ho) void'(q.pop_front());
    if (acc) q.push_back(e);
    mcnt = c ? 0 : (mcnt + int'(ho)) % 16;
    merr = (acc && $countones(s) != 1) || (merr && !c);
  endtask
  task automatic apply_reset();
    rst = 1; in_valid = 0; #1;
    chk("rst_valid", 256'(out_valid), '0);
    chk("rst_data", act, '0);
    chk("rst_ready", 256'(in_ready), '0);
    chk("rst_count", 256'(cnt), '0);
    chk("rst_err", 256'(serr), '0);
    q.delete(); mcnt = 0; merr = 0; prev_stall = 0;
    @(posedge clk); #2; rst = 0; #1;
    chk("post_rst_ready", 256'(in_ready), 256'(1));
  endtask
  task automatic drain();
    bit acc;
    for (int k = 0; k < 10 && q.size() != 0; k++) cyc(0, 1, 0, 10'd4, '0, '0, '0, acc);
    cyc(0, 1, 0, 10'd4, '0, '0, '0, acc);
  endtask
  initial begin
    vec_t tab[6];
    logic [127:0] ra, rb;
    logic [9:0] s;
    bit acc;
    int sent;
    ra = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rb = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    tab[0] = '{10'd4, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3)};
    tab[1] = '{10'd2, pk(32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3)};
    tab[2] = '{10'd1, pk(32'hA0, 32'hA2, 32'hB0, 32'hB2, 32'hA1, 32'hA3, 32'hB1, 32'hB3)};
    tab[3] = '{10'd8, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3)};
    tab[4] = '{10'd3, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3)};
    tab[5] = '{10'd0, pk(32'hA0, 32'hA2, 32'hB0, 32'hB2, 32'hA1, 32'hA3, 32'hB1, 32'hB3)};
    #3;
    apply_reset();
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, tab[i].s, ra, rb, tab[i].e, acc);
    drain();
    cyc(0, 1, 1, 10'd4, '0, '0, '0, acc);
    cyc(1, 1, 1, 10'd3, ra, rb, tab[4].e, acc);
    drain();
    // back-to-back beats held until accepted, consumer alternating ready/stall
    apply_reset();
    sent = 0;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      s = 10'($urandom_range(0, 6));
      cyc(1, k % 2 == 0, 0, s, ra, rb, model(s, ra, rb), acc);
      while (!acc && k < 40) begin
        k++;
        cyc(1, k % 2 == 0, 0, s, ra, rb, model(s, ra, rb), acc);
      end
      sent += int'(acc);
    end
    chk("b2b_sent", 256'(sent), 256'(8));
    drain();
    @(negedge clk);
    chk("b2b_count", 256'(cnt), 256'(8));
    // async reset while stalled with a pending beat
    cyc(1, 0, 0, 10'd3, ra, rb, model(10'd3, ra, rb), acc);
    cyc(0, 0, 0, 10'd3, '0, '0, '0, acc);
    apply_reset();
    cyc(1, 1, 0, 10'd2, ra, rb, model(10'd2, ra, rb), acc);
    drain();
    // counter wrap: 17 beats on a 4-bit counter
    apply_reset();
    for (int i = 0; i < 17; i++) cyc(1, 1, 0, 10'd16, ra, rb, model(10'd16, ra, rb), acc);
    drain();
    @(negedge clk);
    chk("wrap_count", 256'(cnt), 256'(1));
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      s = $urandom_range(0, 1) == 1 ? 10'(1 << $urandom_range(0, 9)) : 10'($urandom_range(0, 1023));
      cyc($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 40 == 0, s, ra, rb, model(s, ra, rb), acc);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
